lcd_spi_writer: RTL and testbench

- Serialises 9-bit LCD words (bit 8 = D/C flag, bits 7:0 = byte) onto the 4-wire SPI link to the panel controller: SCLK, MOSI, DC, CS_N.
- Sits downstream of the character/window generators, which drive `data` with `en_write` and advance on `wr_done`.
- Handles one word per transaction in SPI mode 0, MSB first. Enforces a post-transfer guard gap so upstream has time to present the next word.

---
 rtl/lcd_pkg.sv | 26 ++
 rtl/lcd_spi_tick.sv | 26 ++
 rtl/lcd_spi_writer.sv | 117 +++++++++++
 tb/tb_lcd_spi_writer.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared LCD definitions: writer FSM states, word layout, panel commands and
// the RGB565 palette used by the character/window generators.
package lcd_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_SHIFT = 4'b0010,
        ST_DONE  = 4'b0100,
        ST_GAP   = 4'b1000
    } lcd_state_t;

    localparam int DC_BIT   = 8;
    localparam int BYTE_MSB = 7;

    localparam logic [8:0] CMD_CASET = 9'h02A;
    localparam logic [8:0] CMD_PASET = 9'h02B;
    localparam logic [8:0] CMD_RAMWR = 9'h02C;

    localparam logic [15:0] RGB565_BLACK  = 16'h0000;
    localparam logic [15:0] RGB565_WHITE  = 16'hFFFF;
    localparam logic [15:0] RGB565_RED    = 16'hF800;
    localparam logic [15:0] RGB565_GREEN  = 16'h07E0;
    localparam logic [15:0] RGB565_BLUE   = 16'h001F;
    localparam logic [15:0] RGB565_YELLOW = 16'hFFE0;

endpackage

// File: rtl/lcd_spi_tick.sv
// SCLK half-period divider: one-cycle half_tick every CLK_DIV enabled cycles,
// restarting from zero whenever the enable drops.
module lcd_spi_tick #(
    parameter int CLK_DIV = 2
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic en,
    output logic half_tick
);

    localparam logic [7:0] TERM = 8'(CLK_DIV - 1);

    logic [7:0] cnt;

    always_ff @(posedge sys_clk) begin
        if (sys_rst || !en || cnt == TERM) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

    assign half_tick = en && (cnt == TERM);

endmodule

// File: rtl/lcd_spi_writer.sv
// Serialises one 9-bit LCD word (DC flag + byte) per transaction onto a
// 4-wire mode-0 SPI link, MSB first, followed by a fixed guard gap.
module lcd_spi_writer
    import lcd_pkg::*;
#(
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 4
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       en_write,
    input  logic [8:0] data,
    output logic       wr_done,
    output logic       busy,
    output logic       lcd_sclk,
    output logic       lcd_mosi,
    output logic       lcd_dc,
    output logic       lcd_cs_n
);

    localparam logic [7:0] GAP_TERM = 8'(GAP_CYCLES - 1);

    lcd_state_t state, state_next;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] gap_q, gap_d;
    logic       sclk_d, dc_d, cs_n_d, done_d;
    logic       shift_en, half_tick;

    assign shift_en = (state == ST_SHIFT);

    lcd_spi_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .en       (shift_en),
        .half_tick(half_tick)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state    <= ST_IDLE;
            shift_q  <= '0;
            bit_q    <= '0;
            gap_q    <= '0;
            lcd_sclk <= 1'b0;
            lcd_dc   <= 1'b0;
            lcd_cs_n <= 1'b1;
            wr_done  <= 1'b0;
        end else begin
            state    <= state_next;
            shift_q  <= shift_d;
            bit_q    <= bit_d;
            gap_q    <= gap_d;
            lcd_sclk <= sclk_d;
            lcd_dc   <= dc_d;
            lcd_cs_n <= cs_n_d;
            wr_done  <= done_d;
        end
    end

    always_comb begin
        state_next = state;
        shift_d    = shift_q;
        bit_d      = bit_q;
        gap_d      = gap_q;
        sclk_d     = lcd_sclk;
        dc_d       = lcd_dc;
        cs_n_d     = lcd_cs_n;
        done_d     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (en_write) begin
                    shift_d    = data[BYTE_MSB:0];
                    dc_d       = data[DC_BIT];
                    cs_n_d     = 1'b0;
                    sclk_d     = 1'b0;
                    bit_d      = '0;
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (half_tick) begin
                    sclk_d = ~lcd_sclk;
                    // A high->low toggle ends one bit; the 8th ends the word.
                    if (lcd_sclk) begin
                        if (bit_q == 3'd7) begin
                            done_d     = 1'b1;
                            cs_n_d     = 1'b1;
                            state_next = ST_DONE;
                        end else begin
                            bit_d   = bit_q + 3'd1;
                            shift_d = {shift_q[6:0], 1'b0};
                        end
                    end
                end
            end
            ST_DONE: begin
                gap_d      = '0;
                state_next = ST_GAP;
            end
            ST_GAP: begin
                if (gap_q == GAP_TERM) begin
                    state_next = ST_IDLE;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign lcd_mosi = shift_q[7];
    assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_lcd_spi_writer.sv
// Bench for lcd_spi_writer: two parameterisations, a cycle-level reference
// model feeding an expected-word queue, and a pin-level SPI monitor.
module tb_lcd_spi_writer;

    localparam int DIV_A = 2;
    localparam int GAP_A = 4;
    localparam int DIV_B = 1;
    localparam int GAP_B = 3;

    logic clk = 1'b0;
    int   cyc = 0;

    logic       rst [2];
    logic       en  [2];
    logic [8:0] dat [2];
    logic       wr_done [2];
    logic       busy [2];
    logic       sclk [2];
    logic       mosi [2];
    logic       dc [2];
    logic       cs_n [2];

    int n_tests = 0;
    int n_fail  = 0;

    logic [8:0] exp_q0[$];
    logic [8:0] exp_q1[$];
    int         t0_q0[$];
    int         t0_q1[$];
    int         done_log[$];
    int         mon_nb [2];

    // clock/reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lcd_spi_writer #(.CLK_DIV(DIV_A), .GAP_CYCLES(GAP_A)) u_dut_a (
        .sys_clk (clk),
        .sys_rst (rst[0]),
        .en_write(en[0]),
        .data    (dat[0]),
        .wr_done (wr_done[0]),
        .busy    (busy[0]),
        .lcd_sclk(sclk[0]),
        .lcd_mosi(mosi[0]),
        .lcd_dc  (dc[0]),
        .lcd_cs_n(cs_n[0])
    );

    lcd_spi_writer #(.CLK_DIV(DIV_B), .GAP_CYCLES(GAP_B)) u_dut_b (
        .sys_clk (clk),
        .sys_rst (rst[1]),
        .en_write(en[1]),
        .data    (dat[1]),
        .wr_done (wr_done[1]),
        .busy    (busy[1]),
        .lcd_sclk(sclk[1]),
        .lcd_mosi(mosi[1]),
        .lcd_dc  (dc[1]),
        .lcd_cs_n(cs_n[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // scoreboard queue helpers
    function automatic int exp_count(input int g);
        return (g == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    task automatic push_exp(input int g, input logic [8:0] w, input int t0);
        if (g == 0) begin
            exp_q0.push_back(w);
            t0_q0.push_back(t0);
        end else begin
            exp_q1.push_back(w);
            t0_q1.push_back(t0);
        end
    endtask

    task automatic pop_exp(input int g, output logic [8:0] w, output int t0);
        if (g == 0) begin
            w  = exp_q0.pop_front();
            t0 = t0_q0.pop_front();
        end else begin
            w  = exp_q1.pop_front();
            t0 = t0_q1.pop_front();
        end
    endtask

    task automatic drop_last(input int g);
        if (g == 0) begin
            void'(exp_q0.pop_back());
            void'(t0_q0.pop_back());
        end else begin
            void'(exp_q1.pop_back());
            void'(t0_q1.pop_back());
        end
    endtask

    // Reference model: a word is taken whenever en is high at an edge on which
    // the writer is free; it is then busy for 1+16*div+1+gap cycles.
    task automatic model(input int g, input int div, input int gap);
        int free = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst[g]) begin
                if (exp_count(g) > 0) drop_last(g);
                free = cyc + 1;
            end else if (en[g] && cyc >= free) begin
                push_exp(g, dat[g], cyc);
                free = cyc + 2 + 16 * div + gap;
            end
        end
    endtask

    // Pin monitor: collects MOSI on SCLK rising edges inside the CS window.
    task automatic monitor(input int g, input int div, input int gap);
        logic       prev_sclk = 1'b0;
        logic       in_win    = 1'b0;
        logic       dc0       = 1'b0;
        logic       dc_moved  = 1'b0;
        logic [7:0] bits      = '0;
        logic [8:0] w;
        int         nb = 0;
        int         start = 0;
        int         done_at = -1000;
        int         t0;
        forever begin
            @(posedge clk);
            #1;
            if (rst[g]) begin
                in_win    = 1'b0;
                nb        = 0;
                prev_sclk = 1'b0;
                done_at   = -1000;
            end else begin
                if (cs_n[g] === 1'b0 && !in_win) begin
                    in_win   = 1'b1;
                    start    = cyc;
                    dc0      = dc[g];
                    dc_moved = 1'b0;
                    nb       = 0;
                    bits     = '0;
                end
                if (in_win) begin
                    if (dc[g] !== dc0) dc_moved = 1'b1;
                    if (sclk[g] === 1'b1 && !prev_sclk) begin
                        bits = {bits[6:0], mosi[g]};
                        nb++;
                    end
                end
                prev_sclk = sclk[g];
                if (wr_done[g] === 1'b1) begin
                    if (exp_count(g) == 0) begin
                        check($sformatf("unexpected_wr_done_%0d", g), exp_count(g), 1);
                    end else begin
                        pop_exp(g, w, t0);
                        check($sformatf("word_%0d", g), {dc0, bits}, w);
                        check($sformatf("bit_count_%0d", g), nb, 8);
                        check($sformatf("cs_fall_cycle_%0d", g), start, t0);
                        check($sformatf("wr_done_cycle_%0d", g), cyc, t0 + 16 * div);
                        check($sformatf("dc_stable_%0d", g), dc_moved, 0);
                        check($sformatf("done_pins_%0d", g), {cs_n[g], sclk[g]}, 2'b10);
                    end
                    in_win  = 1'b0;
                    done_at = cyc;
                    done_log.push_back(cyc);
                end
                if (cyc == done_at + gap) check($sformatf("busy_in_gap_%0d", g), busy[g], 1);
                if (cyc == done_at + gap + 1) check($sformatf("busy_idle_%0d", g), busy[g], 0);
            end
            mon_nb[g] = nb;
        end
    endtask

    initial model(0, DIV_A, GAP_A);
    initial model(1, DIV_B, GAP_B);
    initial monitor(0, DIV_A, GAP_A);
    initial monitor(1, DIV_B, GAP_B);

    // driver tasks
    task automatic send(input int g, input logic [8:0] w, input logic [8:0] later);
        @(negedge clk);
        en[g]  = 1'b1;
        dat[g] = w;
        @(negedge clk);
        en[g]  = 1'b0;
        dat[g] = later;
    endtask

    task automatic wait_idle(input int g);
        int n = 0;
        @(negedge clk);
        while ((exp_count(g) != 0 || busy[g] !== 1'b0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("idle_wait_%0d", g), (n < 500), 1);
    endtask

    task automatic check_reset(input int g, input string name);
        check(name, {cs_n[g], sclk[g], mosi[g], dc[g], wr_done[g], busy[g]}, 6'b100000);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [8:0] b2b [3];
        b2b = '{9'h02B, 9'h100, 9'h1EF};
        for (int g = 0; g < 2; g++) begin
            rst[g] = 1'b1;
            en[g]  = 1'b0;
            dat[g] = '0;
        end
        repeat (3) @(negedge clk);
        check_reset(0, "reset_a");
        check_reset(1, "reset_b");
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // command word, data word, data change while shifting
        send(0, 9'h02A, 9'h02A);
        wait_idle(0);
        send(0, 9'h1F8, 9'h000);
        wait_idle(0);
        send(0, 9'h155, 9'h155);
        repeat (10) @(negedge clk);
        dat[0] = 9'h0AA;
        wait_idle(0);

        // back-to-back level request, upstream updates data 2 cycles after wr_done
        done_log.delete();
        @(negedge clk);
        en[0]  = 1'b1;
        dat[0] = b2b[0];
        for (int k = 1; k <= 3; k++) begin
            n = 0;
            while (wr_done[0] !== 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("b2b_done_wait", (n < 200), 1);
            if (k < 3) begin
                repeat (2) @(negedge clk);
                dat[0] = b2b[k];
            end else begin
                en[0] = 1'b0;
            end
        end
        wait_idle(0);
        check("b2b_count", done_log.size(), 3);
        if (done_log.size() == 3) begin
            check("b2b_spacing_1", done_log[1] - done_log[0], 2 + 16 * DIV_A + GAP_A);
            check("b2b_spacing_2", done_log[2] - done_log[1], 2 + 16 * DIV_A + GAP_A);
        end

        // reset after the 3rd SCLK rising edge, then a clean restart
        send(0, 9'h0C3, 9'h0C3);
        n = 0;
        while (mon_nb[0] < 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_wait", (n < 200), 1);
        rst[0] = 1'b1;
        en[0]  = 1'b1;
        dat[0] = 9'h13C;
        @(negedge clk);
        check_reset(0, "reset_mid_shift");
        rst[0] = 1'b0;
        @(negedge clk);
        en[0] = 1'b0;
        wait_idle(0);

        // randomized requests, some landing while busy and being ignored
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 45)) @(negedge clk);
            send(0, 9'($urandom), 9'($urandom));
        end
        wait_idle(0);

        // CLK_DIV=1, GAP_CYCLES=3: single word, then a held request
        send(1, 9'h0FF, 9'h0FF);
        wait_idle(1);
        @(negedge clk);
        en[1]  = 1'b1;
        dat[1] = 9'h0FF;
        repeat (17) @(negedge clk);
        dat[1] = 9'h0AB;
        repeat (8) @(negedge clk);
        en[1] = 1'b0;
        wait_idle(1);
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 25)) @(negedge clk);
            send(1, 9'($urandom), 9'($urandom));
        end
        wait_idle(1);

        check("queue_a_drained", exp_count(0), 0);
        check("queue_b_drained", exp_count(1), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
